// File: rtl/tdm_demux.sv
// tdm_demux: routes framed TDM slot words to channel lanes and re-assembles frames into a double-buffered output
module tdm_demux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int ERRW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic [WIDTH-1:0]        lane_data,
  output logic [SEL_W-1:0]        lane_sel,
  output logic [NUM_CH-1:0]       lane_strobe,
  output logic [NUM_CH*WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [ERRW-1:0]         err_count,
  output logic                    busy
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] slot, slot_n, idx;
  logic [NUM_CH-1:0][WIDTH-1:0] collect, merged;
  logic start, run_word, accept, done, err;
  assign start    = in_valid && in_sof;
  assign run_word = in_valid && !in_sof && state == RUN;
  assign accept   = start || run_word;
  assign done     = run_word && slot == SEL_W'(NUM_CH - 1);
  assign err      = in_valid && (in_sof ? state == RUN : state == HUNT);
  assign idx      = start ? '0 : slot;
  // next state and slot; an SOF always restarts the frame at slot 0
  always_comb begin
    state_n = start ? RUN : done ? HUNT : state;
    slot_n  = start ? SEL_W'(1) : done ? '0 : run_word ? slot + SEL_W'(1) : slot;
  end
  // collect buffer with the incoming word merged into its slot
  always_comb begin
    merged      = collect;
    merged[idx] = in_data;
  end
  // registered state, lane outputs, frame buffer and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      collect     <= '0;
      lane_data   <= '0;
      lane_sel    <= '0;
      lane_strobe <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      if (accept) begin
        collect   <= merged;
        lane_data <= in_data;
        lane_sel  <= idx;
      end
      lane_strobe <= accept ? NUM_CH'(1) << idx : '0;
      if (done) frame_data <= merged;
      frame_valid <= done;
      frame_err   <= err;
      err_count   <= err_count + ERRW'(err && err_count != '1);
      busy        <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux
module tb_tdm_demux;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0, in_sof = 0;
  logic [7:0]  lane_data;
  logic [1:0]  lane_sel;
  logic [3:0]  lane_strobe;
  logic [31:0] frame_data;
  logic        frame_valid, frame_err, busy;
  logic [7:0]  err_count;
  int checks = 0, failures = 0;
  int fv_cnt, fe_cnt;

  tdm_demux dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .lane_data(lane_data), .lane_sel(lane_sel), .lane_strobe(lane_strobe),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    fv_cnt += int'(frame_valid);
    fe_cnt += int'(frame_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    in_valid = 0;
    in_sof = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [7:0] w [8];
    // reset state
    #12;
    chk("rst_strobe", 32'(lane_strobe), 0);
    chk("rst_frame", frame_data, 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lane", 32'(lane_data), 0);
    @(negedge clk);
    rst_n = 1;

    // one frame, one word per cycle
    fv_cnt = 0; fe_cnt = 0;
    step(1, 1, 8'hA1);
    chk("f1_strobe0", 32'(lane_strobe), 32'b0001);
    chk("f1_lane0", 32'(lane_data), 32'hA1);
    chk("f1_sel0", 32'(lane_sel), 0);
    chk("f1_busy", 32'(busy), 1);
    step(1, 0, 8'hB2);
    chk("f1_strobe1", 32'(lane_strobe), 32'b0010);
    chk("f1_sel1", 32'(lane_sel), 1);
    step(1, 0, 8'hC3);
    chk("f1_strobe2", 32'(lane_strobe), 32'b0100);
    chk("f1_fv_early", 32'(frame_valid), 0);
    step(1, 0, 8'hD4);
    chk("f1_strobe3", 32'(lane_strobe), 32'b1000);
    chk("f1_fv", 32'(frame_valid), 1);
    chk("f1_frame", frame_data, 32'hD4C3B2A1);
    chk("f1_busy_end", 32'(busy), 0);
    step(0, 0, 8'h00);
    chk("f1_idle_strobe", 32'(lane_strobe), 0);
    chk("f1_idle_fv", 32'(frame_valid), 0);
    chk("f1_hold_lane", 32'(lane_data), 32'hD4);
    chk("f1_hold_sel", 32'(lane_sel), 3);
    chk("f1_fv_count", 32'(fv_cnt), 1);
    chk("f1_fe_count", 32'(fe_cnt), 0);
    chk("f1_errcnt", 32'(err_count), 0);

    // gapped frame followed back-to-back by a dense frame
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    fv_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, w[i]);
      if (i < 3) begin
        step(0, 0, 8'h00);
        chk("gap_strobe", 32'(lane_strobe), 0);
        step(0, 0, 8'h00);
        chk("gap_frame_hold", frame_data, 32'hD4C3B2A1);
      end
    end
    chk("gap_fv", 32'(frame_valid), 1);
    chk("gap_frame", frame_data, 32'h44332211);
    for (int i = 4; i < 8; i++) begin
      step(1, i == 4, w[i]);
      if (i < 7) chk("b2b_hold", frame_data, 32'h44332211);
    end
    chk("b2b_fv", 32'(frame_valid), 1);
    chk("b2b_frame", frame_data, 32'h88776655);
    chk("b2b_fv_count", 32'(fv_cnt), 2);
    chk("b2b_fe_count", 32'(fe_cnt), 0);

    // early SOF abandons the short frame
    fv_cnt = 0; fe_cnt = 0;
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h10);
    chk("esof_err", 32'(frame_err), 1);
    chk("esof_errcnt", 32'(err_count), 1);
    chk("esof_strobe", 32'(lane_strobe), 32'b0001);
    chk("esof_busy", 32'(busy), 1);
    step(1, 0, 8'h20);
    chk("esof_err_clear", 32'(frame_err), 0);
    step(1, 0, 8'h30);
    step(1, 0, 8'h40);
    chk("esof_frame", frame_data, 32'h40302010);
    step(0, 0, 8'h00);
    chk("esof_fv_count", 32'(fv_cnt), 1);
    chk("esof_fe_count", 32'(fe_cnt), 1);

    // orphan words with no SOF after reset
    do_reset();
    fv_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'(8'h70 + i));
      chk("orph_strobe", 32'(lane_strobe), 0);
      chk("orph_err", 32'(frame_err), 1);
      chk("orph_busy", 32'(busy), 0);
    end
    chk("orph_errcnt", 32'(err_count), 3);
    chk("orph_fv_count", 32'(fv_cnt), 0);
    chk("orph_frame", frame_data, 0);

    // asynchronous reset mid-frame
    do_reset();
    fv_cnt = 0; fe_cnt = 0;
    step(1, 1, 8'h9A);
    step(1, 0, 8'h9B);
    #2;
    rst_n = 0;
    in_valid = 0;
    in_sof = 0;
    #1;
    chk("arst_lane", 32'(lane_data), 0);
    chk("arst_sel", 32'(lane_sel), 0);
    chk("arst_strobe", 32'(lane_strobe), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) step(1, i == 0, 8'(i + 1));
    chk("arst_frame", frame_data, 32'h04030201);
    chk("arst_fv", 32'(frame_valid), 1);
    chk("arst_fv_count", 32'(fv_cnt), 1);
    chk("arst_fe_count", 32'(fe_cnt), 0);
    chk("arst_errcnt", 32'(err_count), 0);

    // error counter saturation
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      step(1, 0, 8'h5A);
      if (i == 254) chk("sat_254", 32'(err_count), 254);
      if (i == 255) chk("sat_255", 32'(err_count), 255);
    end
    chk("sat_err_last", 32'(frame_err), 1);
    chk("sat_hold", 32'(err_count), 255);
    step(0, 0, 8'h00);
    chk("sat_err_idle", 32'(frame_err), 0);
    chk("sat_hold_idle", 32'(err_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
